// File: rtl/coin_pkg.sv
// Coin codes and emitter states shared by the coin input path and the vending FSM.
package coin_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } emit_state_t;

    // Counter width for a debouncer that must count up to n disagreeing edges.
    function automatic int unsigned debounce_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

    // Counter width for a gap counter running 0..n-1; never narrower than one bit.
    function automatic int unsigned gap_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin switch: two-flop synchroniser, consecutive-disagreement debouncer and a
// single-cycle pulse on each debounced rising edge.
module coin_debounce
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);

    localparam int unsigned   CW       = debounce_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1_q, s2_q;
    logic          db_q, db_prev_q;
    logic          db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Two-flop synchroniser for the asynchronous switch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw;
            s2_q <= s1_q;
        end
    end

    // Flip the debounced level on the DEBOUNCE_CYCLES-th consecutive disagreeing edge.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounced level, its one-cycle-old copy and the disagreement counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            db_q      <= db_d;
            db_prev_q <= db_q;
            cnt_q     <= cnt_d;
        end
    end

    assign rise = db_q & ~db_prev_q;

endmodule

// File: rtl/coin_in_conditioner.sv
// Conditions the two raw coin switches and serialises their insertions into
// single-cycle coin codes, each followed by GAP_CYCLES idle cycles.
module coin_in_conditioner
    import coin_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES      = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Coin_half_raw,
    input  logic       Coin_one_raw,
    output logic [1:0] D_in,
    output logic       Busy,
    output logic       Coin_err
);

    localparam int unsigned   GW       = gap_width(GAP_CYCLES);
    // Wraps when GAP_CYCLES is 0; the GAP state is never entered in that case.
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    logic          rise_half, rise_one;
    logic          pend_half_q, pend_half_d;
    logic          pend_one_q, pend_one_d;
    logic          err_q, err_d;
    logic          take_half, take_one;
    logic          ready;
    emit_state_t   state_q, state_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic [1:0]    code_q, code_d;

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_half (
        .clk  (Clk),
        .rst_n(Reset),
        .raw  (Coin_half_raw),
        .rise (rise_half)
    );

    coin_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db_one (
        .clk  (Clk),
        .rst_n(Reset),
        .raw  (Coin_one_raw),
        .rise (rise_one)
    );

    // Emitter state, gap counter and the registered coin code.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q   <= IDLE;
            gap_cnt_q <= '0;
            code_q    <= COIN_NONE;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            code_q    <= code_d;
        end
    end

    // Next emitter state; the last gap cycle dispatches directly so the gap is exact.
    always_comb begin
        ready     = (state_q == IDLE)
                 || ((state_q == EMIT) && (GAP_CYCLES == 0))
                 || ((state_q == GAP) && (gap_cnt_q == GAP_LAST));
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        take_one  = 1'b0;
        take_half = 1'b0;
        if (ready) begin
            gap_cnt_d = '0;
            if (pend_one_q) begin
                state_d  = EMIT;
                take_one = 1'b1;
            end else if (pend_half_q) begin
                state_d   = EMIT;
                take_half = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q == EMIT) begin
            state_d   = GAP;
            gap_cnt_d = '0;
        end else if (state_q == GAP) begin
            gap_cnt_d = gap_cnt_q + 1'b1;
        end
    end

    // Code to register for the next cycle: the dispatched coin, otherwise none.
    always_comb begin
        code_d = COIN_NONE;
        if (take_one) begin
            code_d = COIN_ONE;
        end else if (take_half) begin
            code_d = COIN_HALF;
        end
    end

    // A request into a full slot that is not being drained this cycle is an overflow.
    always_comb begin
        pend_one_d  = (pend_one_q & ~take_one) | rise_one;
        pend_half_d = (pend_half_q & ~take_half) | rise_half;
        err_d       = (rise_one & pend_one_q & ~take_one)
                    | (rise_half & pend_half_q & ~take_half);
    end

    // Pending slots and the overflow pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            pend_one_q  <= 1'b0;
            pend_half_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            pend_one_q  <= pend_one_d;
            pend_half_q <= pend_half_d;
            err_q       <= err_d;
        end
    end

    assign D_in     = code_q;
    assign Coin_err = err_q;
    assign Busy     = (state_q != IDLE) | pend_one_q | pend_half_q;

endmodule
